// File: rtl/mem_stage_ctrl.sv
// MIPS memory-stage controller: drives a req/ack data-memory bus, stalls upstream during
// loads/stores, and registers the MEM/WB fields. Optional REQ timeout via MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl
`ifdef MEM_STAGE_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 16)
`endif
(
  input  logic        clock__i,
  input  logic        reset_n__i,
  input  logic        RegWrite__i,
  input  logic        MemToReg__i,
  input  logic        MemRead__i,
  input  logic        MemWrite__i,
  input  logic [31:0] ALUData__i,
  input  logic [31:0] MemWriteData__i,
  input  logic [4:0]  WBReg__i,
  output logic        DMemReq__o,
  output logic        DMemWe__o,
  output logic [31:0] DMemAddr__o,
  output logic [31:0] DMemWData__o,
  input  logic        DMemAck__i,
  input  logic [31:0] DMemRData__i,
  output logic        Stall__o,
  output logic        RegWrite__o,
  output logic [4:0]  WBReg__o,
  output logic [31:0] WBData__o,
  output logic        Timeout__o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_reg, state_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        regwrite_reg, regwrite_next;
  logic [4:0]  wbreg_reg, wbreg_next;
  logic [31:0] wbdata_reg, wbdata_next;
  logic        access;
  logic        stall;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [15:0] cnt_reg, cnt_next;
  logic        timeout_reg, timeout_next;
`endif

  assign access = MemRead__i | MemWrite__i;
  // The access stays presented through DONE; releasing the stall there lets EX/MEM advance.
  assign stall  = access & (state_reg != DONE);

  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    regwrite_next = regwrite_reg;
    wbreg_next    = wbreg_reg;
    wbdata_next   = wbdata_reg;
`ifdef MEM_STAGE_TIMEOUT_EN
    cnt_next      = cnt_reg;
    timeout_next  = timeout_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (access) begin
          state_next = REQ;
          req_next   = 1'b1;
          we_next    = MemWrite__i;
          addr_next  = ALUData__i;
          wdata_next = MemWriteData__i;
`ifdef MEM_STAGE_TIMEOUT_EN
          cnt_next   = 16'd0;
`endif
        end
      end
      REQ: begin
        if (DMemAck__i) begin
          rdata_next = DMemRData__i;
          req_next   = 1'b0;
          state_next = DONE;
        end
`ifdef MEM_STAGE_TIMEOUT_EN
        else if (cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
          rdata_next   = 32'hDEADBEEF;
          req_next     = 1'b0;
          timeout_next = 1'b1;
          state_next   = DONE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
`endif
      end
      DONE: state_next = IDLE;
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    // A stalled edge inserts a bubble into MEM/WB; register and data fields hold.
    if (!stall) begin
      regwrite_next = RegWrite__i;
      wbreg_next    = WBReg__i;
      wbdata_next   = MemToReg__i ? rdata_reg : ALUData__i;
    end else begin
      regwrite_next = 1'b0;
    end
  end

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      rdata_reg    <= 32'd0;
      regwrite_reg <= 1'b0;
      wbreg_reg    <= 5'd0;
      wbdata_reg   <= 32'd0;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_reg      <= 16'd0;
      timeout_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      regwrite_reg <= regwrite_next;
      wbreg_reg    <= wbreg_next;
      wbdata_reg   <= wbdata_next;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_reg      <= cnt_next;
      timeout_reg  <= timeout_next;
`endif
    end
  end

  assign DMemReq__o   = req_reg;
  assign DMemWe__o    = we_reg;
  assign DMemAddr__o  = addr_reg;
  assign DMemWData__o = wdata_reg;
  assign Stall__o     = stall;
  assign RegWrite__o  = regwrite_reg;
  assign WBReg__o     = wbreg_reg;
  assign WBData__o    = wbdata_reg;
`ifdef MEM_STAGE_TIMEOUT_EN
  assign Timeout__o   = timeout_reg;
`else
  assign Timeout__o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected MEM/WB fields queued per instruction,
// popped on the edge where the stage releases the stall.
module tb_mem_stage_ctrl;

  localparam int TMO = 16;

  logic        clock, reset_n;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUData_i, MemWriteData_i;
  logic [4:0]  WBReg_i;
  logic        DMemReq, DMemWe, DMemAck;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic        Stall, RegWrite_o, Timeout;
  logic [4:0]  WBReg_o;
  logic [31:0] WBData_o;

  typedef struct packed {
    logic        rw;
    logic [4:0]  wbreg;
    logic [31:0] data;
  } wb_t;

  wb_t         sb[$];
  logic [31:0] model_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_stage_ctrl dut (
    .clock__i        (clock),
    .reset_n__i      (reset_n),
    .RegWrite__i     (RegWrite_i),
    .MemToReg__i     (MemToReg_i),
    .MemRead__i      (MemRead_i),
    .MemWrite__i     (MemWrite_i),
    .ALUData__i      (ALUData_i),
    .MemWriteData__i (MemWriteData_i),
    .WBReg__i        (WBReg_i),
    .DMemReq__o      (DMemReq),
    .DMemWe__o       (DMemWe),
    .DMemAddr__o     (DMemAddr),
    .DMemWData__o    (DMemWData),
    .DMemAck__i      (DMemAck),
    .DMemRData__i    (DMemRData),
    .Stall__o        (Stall),
    .RegWrite__o     (RegWrite_o),
    .WBReg__o        (WBReg_o),
    .WBData__o       (WBData_o),
    .Timeout__o      (Timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   32'(DMemReq),    32'd0);
    chk({tag, "_we"},    32'(DMemWe),     32'd0);
    chk({tag, "_addr"},  DMemAddr,        32'd0);
    chk({tag, "_wdata"}, DMemWData,       32'd0);
    chk({tag, "_stall"}, 32'(Stall),      32'd0);
    chk({tag, "_rw"},    32'(RegWrite_o), 32'd0);
    chk({tag, "_wbreg"}, 32'(WBReg_o),    32'd0);
    chk({tag, "_wbdata"},WBData_o,        32'd0);
    chk({tag, "_tmo"},   32'(Timeout),    32'd0);
  endtask

  task automatic clear_inputs();
    RegWrite_i = 0; MemToReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    ALUData_i = 0; MemWriteData_i = 0; WBReg_i = 0;
    DMemAck = 0; DMemRData = 0;
  endtask

  // k >= 0: ack in REQ cycle k; k < 0: never ack (timeout path).
  task automatic run_instr(input logic rw, input logic m2r, input logic mr, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                           input int k, input logic [31:0] rd, input logic spur);
    logic access;
    logic done;
    int   nstall;
    int   exp_stall;
    wb_t  e;
    access = mr | mw;
    @(negedge clock);
    RegWrite_i = rw; MemToReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
    ALUData_i = alu; MemWriteData_i = wd; WBReg_i = wr;
    if (spur) begin
      DMemAck = 1'b1;
      DMemRData = 32'h1111_1111;
    end
    if (access) model_rdata = (k < 0) ? 32'hDEADBEEF : rd;
    e.rw = rw;
    e.wbreg = wr;
    e.data = m2r ? model_rdata : alu;
    sb.push_back(e);
    nstall = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (!Stall) begin
        done = 1'b1;
      end else begin
        nstall++;
        if (i == 0) begin
          chk("req_low_before", 32'(DMemReq), 32'd0);
        end else begin
          chk("req_held", 32'(DMemReq), 32'd1);
          chk("we_held", 32'(DMemWe), 32'(mw));
          chk("addr_held", DMemAddr, alu);
          chk("wdata_held", DMemWData, wd);
          chk("bubble_rw", 32'(RegWrite_o), 32'd0);
        end
        if (k >= 0 && i == k + 1) begin
          DMemAck = 1'b1;
          DMemRData = rd;
        end
        @(posedge clock);
        #1;
        DMemAck = 1'b0;
        @(negedge clock);
      end
    end
    exp_stall = access ? ((k < 0) ? TMO + 1 : k + 2) : 0;
    chk("stall_cycles", 32'(nstall), 32'(exp_stall));
    @(posedge clock);
    #1;
    DMemAck = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("wb_rw", 32'(RegWrite_o), 32'(e.rw));
      chk("wb_reg", 32'(WBReg_o), 32'(e.wbreg));
      chk("wb_data", WBData_o, e.data);
      chk("req_after", 32'(DMemReq), 32'd0);
    end
    $display("instr rw=%0d m2r=%0d rd=%0d wr=%0d alu=0x%08h -> stall=%0d wb=(%0d,%0d,0x%08h)",
             rw, m2r, mr, mw, alu, nstall, RegWrite_o, WBReg_o, WBData_o);
  endtask

  initial begin
    clear_inputs();
    model_rdata = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_all_zero("post_reset");

    // ALU op passes in one edge with no stall.
    run_instr(1, 0, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0, 0);
    // Load, ack after 3 REQ cycles.
    run_instr(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hCAFEF00D, 0);
    // Store, ack in the first REQ cycle.
    run_instr(0, 0, 0, 1, 32'h0000_0020, 32'hA5A5A5A5, 5'd0, 0, 32'h5555_AAAA, 0);
    // Back-to-back loads; the second starts with a spurious ack while IDLE.
    run_instr(1, 1, 1, 0, 32'h0000_0200, 32'h0, 5'd8, 1, 32'h1234_5678, 0);
    run_instr(1, 1, 1, 0, 32'h0000_0204, 32'h0, 5'd9, 0, 32'h0BAD_F00D, 1);
    // Non-access MemToReg with a spurious ack: rdata_q must be unchanged.
    run_instr(1, 1, 0, 0, 32'h0000_0999, 32'h0, 5'd10, 0, 32'h0, 1);
    // Read and write both set behaves as a write.
    run_instr(0, 0, 1, 1, 32'h0000_0040, 32'h0F0F_0F0F, 5'd3, 2, 32'h7777_7777, 0);
    // Random ALU ops.
    for (int n = 0; n < 4; n++)
      run_instr(1'($urandom_range(0, 1)), 0, 0, 0, $urandom, 32'h0, 5'($urandom_range(0, 31)), 0, 32'h0, 0);

`ifdef MEM_STAGE_TIMEOUT_EN
    run_instr(1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd11, -1, 32'h0, 0);
    chk("timeout_set", 32'(Timeout), 32'd1);
    run_instr(1, 0, 0, 0, 32'h0000_0042, 32'h0, 5'd12, 0, 32'h0, 0);
    chk("timeout_sticky", 32'(Timeout), 32'd1);
`else
    chk("timeout_tied", 32'(Timeout), 32'd0);
`endif

    // Reset in the middle of a REQ drops the request asynchronously.
    @(negedge clock);
    MemRead_i = 1; MemToReg_i = 1; RegWrite_i = 1; ALUData_i = 32'h0000_0500; WBReg_i = 5'd4;
    @(posedge clock);
    #2;
    chk("req_before_rst", 32'(DMemReq), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("req_async_drop", 32'(DMemReq), 32'd0);
    clear_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_all_zero("mid_rst");
    model_rdata = 32'd0;
    // State must be IDLE again: a fresh load sees the normal stall length.
    run_instr(1, 1, 1, 0, 32'h0000_0600, 32'h0, 5'd6, 1, 32'h600D_DA7A, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the 5-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the EX/MEM control and data fields and drives a request/acknowledge data-memory bus. It stalls the upstream pipeline for the whole duration of each load or store. It produces the registered write-back fields (RegWrite, WBReg, WBData) consumed by the WB stage.

## Interface
- TIMEOUT_CYCLES, 16, REQ-state cycles without ack before abort (only with macro)

- clock__i  in  1  pipeline clock
- reset_n__i  in  1  reset, asynchronous, active-low
- RegWrite__i, MemToReg__i, MemRead__i, MemWrite__i  in  1 each  EX/MEM control fields
- ALUData__i  in  32  EX/MEM ALU result / memory address
- MemWriteData__i  in  32  EX/MEM store data
- WBReg__i  in  5  EX/MEM destination register
- DMemReq__o  out  1  memory request, registered
- DMemWe__o  out  1  1 = write, 0 = read; valid with DMemReq__o
- DMemAddr__o  out  32  byte address, registered
- DMemWData__o  out  32  store data, registered
- DMemAck__i  in  1  memory acknowledge, single-cycle pulse
- DMemRData__i  in  32  load data, valid when DMemAck__i = 1
- Stall__o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; combinational
- RegWrite__o  out  1  MEM/WB write enable
- WBReg__o  out  5  MEM/WB destination register
- WBData__o  out  32  MEM/WB write-back data
- Timeout__o  out  1  sticky timeout error flag

## Operation
- access = MemRead__i | MemWrite__i. Both set means write: DMemWe__o = 1.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if access, go to REQ; load DMemReq__o = 1, DMemWe__o = MemWrite__i, DMemAddr__o = ALUData__i, DMemWData__o = MemWriteData__i.
  - REQ: hold req/addr/we/wdata stable. On DMemAck__i = 1, capture DMemRData__i into rdata_q, drop DMemReq__o, go to DONE.
  - DONE: go unconditionally to IDLE.
- DMemAck__i outside REQ is ignored.
- Stall__o = access & (state != DONE).
- MEM/WB update at each posedge:
  - Stall__o = 0: RegWrite__o <= RegWrite__i, WBReg__o <= WBReg__i, WBData__o <= MemToReg__i ? rdata_q : ALUData__i.
  - Stall__o = 1: RegWrite__o <= 0 (bubble); WBReg__o and WBData__o hold.
- Non-access instructions pass with no stall.

## Timing
- Reset values: all outputs 0, state IDLE, rdata_q 0, Timeout__o 0.
- Asserting reset mid-access drops DMemReq__o immediately; the access is abandoned.
- Load/store with ack on cycle k after REQ entry (k ≥ 0):
  - Stall__o is high for k+2 cycles.
  - MEM/WB loads at the end of cycle k+2, relative to the first cycle the access is presented.
- Minimum access occupancy is 3 cycles (2 stall cycles).
- Non-access latency: 1 edge, EX/MEM to MEM/WB.
- Back-to-back accesses: DONE→IDLE, then the next access stalls again.
- There is no overlap of requests; at most one request is outstanding.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A 16-bit counter runs in REQ.
  - If it reaches TIMEOUT_CYCLES with no ack: drop req, set rdata_q = 32'hDEADBEEF, go to DONE, set Timeout__o = 1.
  - Timeout__o is sticky until reset.
  - The counter clears on REQ entry.
- MEM_STAGE_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; Timeout__o is tied 0.

## Test plan
- Reset asserted during REQ → DMemReq__o = 0 asynchronously; after release, state IDLE and all outputs 0.
- ALU op (RegWrite=1, WBReg=5, ALUData=0x1234, no access) → Stall__o = 0; next edge RegWrite__o=1, WBReg__o=5, WBData__o=0x1234.
- Load (MemRead=1, MemToReg=1, ALUData=0x100), ack after 3 REQ cycles with RData=0xCAFEF00D:
  - DMemReq__o=1, DMemWe__o=0, DMemAddr__o=0x100 held.
  - Stall__o high for 5 cycles.
  - WBData__o=0xCAFEF00D; RegWrite__o=0 bubbles during the stall.
- Store (MemWrite=1, ALUData=0x20, MemWriteData=0xA5A5A5A5), ack in first REQ cycle → DMemWe__o=1 with that data; 2 stall cycles; RegWrite__o=0.
- Two back-to-back loads → two separate request pulses with no overlap; WB values in order; spurious ack in IDLE ignored.
- With MEM_STAGE_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, no ack → after 16 REQ cycles DMemReq__o=0, WBData__o=0xDEADBEEF, Timeout__o=1 and it stays 1.
